// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : writeback_arbiter_pkg                                       |
// | Brief    : Shared widths and types for the register-file write-back.   |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
package writeback_arbiter_pkg;

    localparam int OPERAND_WIDTH             = 32;
    localparam int REGISTER_SIZE             = 32;
    localparam int REGISTER_DESCRIPTOR_WIDTH = $clog2(REGISTER_SIZE);
    localparam int NUM_WB_UNITS              = 4;

    typedef logic [OPERAND_WIDTH-1:0]             operand_t;
    typedef logic [REGISTER_DESCRIPTOR_WIDTH-1:0] reg_desc_t;

    // Index following idx in a ring of n slots.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : writeback_arbiter_if                                        |
// | Brief    : Unit request bundle and register-file write-back port.      |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
interface writeback_arbiter_if #(
    parameter int NUM_UNITS = writeback_arbiter_pkg::NUM_WB_UNITS
);
    import writeback_arbiter_pkg::*;

    logic [NUM_UNITS-1:0]                                req_valid_input;
    logic [NUM_UNITS-1:0]                                req_ready_output;
    logic [NUM_UNITS-1:0][REGISTER_DESCRIPTOR_WIDTH-1:0] req_register_input;
    logic [NUM_UNITS-1:0][OPERAND_WIDTH-1:0]             req_result_input;
    logic                                                write_back_output;
    reg_desc_t                                           write_back_register_output;
    operand_t                                            result_output;
    logic [NUM_UNITS-1:0]                                grant_output;
    logic                                                busy_output;

    modport slave (
        input  req_valid_input, req_register_input, req_result_input,
        output req_ready_output, write_back_output, write_back_register_output,
        output result_output, grant_output, busy_output
    );

    modport master (
        output req_valid_input, req_register_input, req_result_input,
        input  req_ready_output, write_back_output, write_back_register_output,
        input  result_output, grant_output, busy_output
    );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_round_robin_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : round_robin_arbiter                                         |
// | Brief    : Stateless one-hot pick of the first request at/after ptr.   |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module round_robin_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0]   i_req,
    input  wire logic [PTR_WIDTH-1:0] i_ptr,
    output logic      [NUM_REQ-1:0]   o_grant
);

    // Walk priority offsets from the pointer; the first requester seen wins.
    always_comb begin
        int w_pos;
        logic w_found;
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_pos = int'(i_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && (j == w_pos)) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : writeback_arbiter                                           |
// | Brief    : Per-unit result buffers sharing one registered write port.  |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = NUM_WB_UNITS
) (
    input  wire logic              clk,
    input  wire logic              rst,
    writeback_arbiter_if.slave     bus
);

    localparam int c_PTR_WIDTH = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]   r_full;
    reg_desc_t              r_reg  [NUM_UNITS];
    operand_t               r_data [NUM_UNITS];
    logic [c_PTR_WIDTH-1:0] r_ptr;

    logic                   r_wb;
    reg_desc_t              r_wb_reg;
    operand_t               r_wb_data;
    logic [NUM_UNITS-1:0]   r_grant;

    logic [NUM_UNITS-1:0]   w_sel;
    logic [NUM_UNITS-1:0]   w_ready;
    logic [NUM_UNITS-1:0]   w_accept;
    reg_desc_t              w_mux_reg;
    operand_t               w_mux_data;
    logic [c_PTR_WIDTH-1:0] w_ptr_next;

    round_robin_arbiter #(
        .NUM_REQ   (NUM_UNITS),
        .PTR_WIDTH (c_PTR_WIDTH)
    ) u_rr (
        .i_req   (r_full),
        .i_ptr   (r_ptr),
        .o_grant (w_sel)
    );

    // A buffer being drained this cycle can be refilled at the same edge.
    assign w_ready  = ~r_full | w_sel;
    assign w_accept = bus.req_valid_input & w_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!rst) begin
                r_full[i] <= 1'b0;
            end else if (w_accept[i]) begin
                r_full[i] <= 1'b1;
                r_reg[i]  <= bus.req_register_input[i];
                r_data[i] <= bus.req_result_input[i];
            end else if (w_sel[i]) begin
                r_full[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mux_reg  = '0;
        w_mux_data = '0;
        w_ptr_next = r_ptr;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_sel[i]) begin
                w_mux_reg  = r_reg[i];
                w_mux_data = r_data[i];
                w_ptr_next = c_PTR_WIDTH'(wrap_inc(i, NUM_UNITS));
            end
        end
    end

    // Register/result hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_wb      <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
            r_grant   <= '0;
        end else begin
            r_ptr   <= w_ptr_next;
            r_wb    <= |w_sel;
            r_grant <= w_sel;
            if (|w_sel) begin
                r_wb_reg  <= w_mux_reg;
                r_wb_data <= w_mux_data;
            end
        end
    end

    assign bus.req_ready_output           = w_ready;
    assign bus.write_back_output          = r_wb;
    assign bus.write_back_register_output = r_wb_reg;
    assign bus.result_output              = r_wb_data;
    assign bus.grant_output               = r_grant;
    assign bus.busy_output                = (|r_full) | r_wb;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_writeback_arbiter                                        |
// | Brief    : Self-checking bench for writeback_arbiter (NUM_UNITS=4).    |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_UNITS(N)) bus();

    writeback_arbiter #(.NUM_UNITS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [3:0]  grant;
    } wb_exp_t;

    typedef struct {
        int          unit;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [3:0]  exp_grant;
    } single_t;

    wb_exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [4:0] rg, input logic [31:0] d, input logic [3:0] g);
        sb.push_back('{c, rg, d, g});
    endtask

    task automatic drive(input int unit, input logic [4:0] rg, input logic [31:0] d);
        bus.req_valid_input[unit]    = 1'b1;
        bus.req_register_input[unit] = rg;
        bus.req_result_input[unit]   = d;
    endtask

    task automatic idle();
        bus.req_valid_input = '0;
    endtask

    function automatic logic [31:0] tdata(input int u, input int k);
        return {16'hC0DE, 8'(u), 8'(k)};
    endfunction

    // Scoreboard: every write-back must match the next expected record, cycle included.
    always @(negedge clk) begin
        if (bus.write_back_output === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got reg=%0d data=0x%0h grant=%b, want no write (cycle %0d)",
                         bus.write_back_register_output, bus.result_output, bus.grant_output, cyc);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_cycle", 64'(cyc), 64'(e.cyc));
                check("wb_reg",   64'(bus.write_back_register_output), 64'(e.rg));
                check("wb_data",  64'(bus.result_output), 64'(e.data));
                check("wb_grant", 64'(bus.grant_output), 64'(e.grant));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        single_t tbl[4];
        int      alt_u[9];
        int      alt_k[9];
        int      n;

        tbl[0] = '{2, 5'd5,  32'hDEADBEEF, 4'b0100};
        tbl[1] = '{0, 5'd0,  32'h00000000, 4'b0001};
        tbl[2] = '{1, 5'd31, 32'hFFFFFFFF, 4'b0010};
        tbl[3] = '{3, 5'd17, 32'hA5A5A5A5, 4'b1000};
        alt_u  = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        alt_k  = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

        // Reset with garbage on the request inputs
        rst = 1'b0;
        bus.req_valid_input    = 4'hF;
        bus.req_register_input = {4{5'(($urandom))}};
        bus.req_result_input   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        rst = 1'b1;
        idle();
        #1;
        check("rst_wb",     64'(bus.write_back_output), 64'd0);
        check("rst_reg",    64'(bus.write_back_register_output), 64'd0);
        check("rst_result", 64'(bus.result_output), 64'd0);
        check("rst_grant",  64'(bus.grant_output), 64'd0);
        check("rst_ready",  64'(bus.req_ready_output), 64'hF);
        check("rst_busy",   64'(bus.busy_output), 64'd0);

        // Single requests, one unit at a time
        for (int t = 0; t < 4; t++) begin
            tick();
            check("idle_ready", 64'(bus.req_ready_output), 64'hF);
            check("idle_busy",  64'(bus.busy_output), 64'd0);
            n = cyc;
            drive(tbl[t].unit, tbl[t].rg, tbl[t].data);
            push(n + 2, tbl[t].rg, tbl[t].data, tbl[t].exp_grant);
            tick();
            idle();
            #1;
            check("single_busy",  64'(bus.busy_output), 64'd1);
            check("single_ready", 64'(bus.req_ready_output), 64'hF);
            tick();
            tick();
            check("single_wb_off", 64'(bus.write_back_output), 64'd0);
            check("single_idle",   64'(bus.busy_output), 64'd0);
        end

        // All four units in one cycle, pointer at 0
        n = cyc;
        for (int u = 0; u < 4; u++) begin
            drive(u, 5'(u + 1), 32'(8'h11 * (u + 1)));
            push(n + 2 + u, 5'(u + 1), 32'(8'h11 * (u + 1)), 4'(1 << u));
        end
        tick();
        idle();
        #1;
        check("all_full_ready", 64'(bus.req_ready_output), 64'b0001);
        repeat (5) tick();
        check("all_done_wb", 64'(bus.write_back_output), 64'd0);

        // Pointer back at 0: unit 1 wins over unit 3
        n = cyc;
        drive(1, 5'd9,  32'h9999_0001);
        drive(3, 5'd13, 32'h1313_0003);
        push(n + 2, 5'd9,  32'h9999_0001, 4'b0010);
        push(n + 3, 5'd13, 32'h1313_0003, 4'b1000);
        tick();
        idle();
        repeat (3) tick();

        // Unit 0 alone moves the pointer to 1
        n = cyc;
        drive(0, 5'd6, 32'h6666_0000);
        push(n + 2, 5'd6, 32'h6666_0000, 4'b0001);
        tick();
        idle();
        repeat (2) tick();

        // Units 0 and 1 streaming: alternating grants, no loss or duplication
        n = cyc;
        for (int j = 0; j < 9; j++) begin
            push(n + 2 + j, 5'(10 + alt_u[j]), tdata(alt_u[j], alt_k[j]), 4'(1 << alt_u[j]));
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 5'd10, tdata(0, k));
            drive(1, 5'd11, tdata(1, k));
            #1;
            if (k == 0)
                check("stream_ready", 64'(bus.req_ready_output), 64'b1111);
            else if (k % 2 == 1)
                check("stream_ready", 64'(bus.req_ready_output), 64'b1110);
            else
                check("stream_ready", 64'(bus.req_ready_output), 64'b1101);
            tick();
        end
        idle();
        repeat (3) tick();
        check("stream_done_wb",   64'(bus.write_back_output), 64'd0);
        check("stream_done_busy", 64'(bus.busy_output), 64'd0);

        // Unit 3 full and waiting: a new valid must be refused
        n = cyc;
        drive(2, 5'd20, 32'h2020_AAAA);
        drive(3, 5'd23, 32'h2323_BBBB);
        push(n + 2, 5'd20, 32'h2020_AAAA, 4'b0100);
        push(n + 3, 5'd23, 32'h2323_BBBB, 4'b1000);
        tick();
        idle();
        drive(3, 5'd24, 32'hCCCC_3333);
        #1;
        check("blocked_ready", 64'(bus.req_ready_output), 64'b0111);
        tick();
        idle();
        #1;
        check("unblocked_ready", 64'(bus.req_ready_output), 64'hF);
        repeat (2) tick();
        check("blocked_done_busy", 64'(bus.busy_output), 64'd0);

        // Reset while three buffers are full: pending results are dropped
        drive(0, 5'd1, 32'h6000_0000);
        drive(1, 5'd2, 32'h6000_0001);
        drive(2, 5'd3, 32'h6000_0002);
        tick();
        idle();
        rst = 1'b0;
        #1;
        check("pre_rst_busy", 64'(bus.busy_output), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_wb",    64'(bus.write_back_output), 64'd0);
        check("midrst_ready", 64'(bus.req_ready_output), 64'hF);
        check("midrst_busy",  64'(bus.busy_output), 64'd0);
        tick();
        check("midrst_wb2",   64'(bus.write_back_output), 64'd0);

        n = cyc;
        drive(1, 5'd7, 32'h7777_7777);
        drive(3, 5'd8, 32'h8888_8888);
        push(n + 2, 5'd7, 32'h7777_7777, 4'b0010);
        push(n + 3, 5'd8, 32'h8888_8888, 4'b1000);
        tick();
        idle();
        repeat (5) tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Shares the global register file's single write-back port among `NUM_UNITS` execution units.
- Each unit has a one-entry result buffer and a valid/ready handshake.
- A round-robin scheduler selects one buffered result per cycle and drives `write_back_input`, `write_back_register_input` and `result_input` of the register file from a registered output stage.
- Sits between the execution units and the register file; clearing the reservation on write-back is still done by the register file.

## Interface

Parameters:
- `NUM_UNITS`, 4: number of requesting execution units (≥2).
- `OPERAND_WIDTH`, `REGISTER_DESCRIPTOR_WIDTH`: taken from the shared params package, not overridden locally.

Ports (clock and reset: one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-low
- `req_valid_input`  in  NUM_UNITS  unit i presents a result
- `req_ready_output`  out  NUM_UNITS  unit i's buffer can accept this cycle
- `req_register_input`  in  NUM_UNITS×REGISTER_DESCRIPTOR_WIDTH  destination register per unit
- `req_result_input`  in  NUM_UNITS×OPERAND_WIDTH  result data per unit
- `write_back_output`  out  1  write strobe to the register file
- `write_back_register_output`  out  REGISTER_DESCRIPTOR_WIDTH  destination register
- `result_output`  out  OPERAND_WIDTH  data written
- `grant_output`  out  NUM_UNITS  one-hot: unit whose result is on the outputs this cycle
- `busy_output`  out  1  any buffer full or write_back_output high

## Operation

- Per-unit buffer state:
  - `full[i]`, `reg[i]`, `data[i]`.
  - `req_ready_output[i] = !full[i] | sel[i]`, where `sel` is this cycle's arbiter pick. This allows back-to-back acceptance while draining.
  - Accept: `req_valid_input[i] & req_ready_output[i]`. The buffer loads at the edge; `full[i]` becomes or stays 1.
  - Drain: when `sel[i]` and no accept, `full[i]` clears at the edge.
- Arbitration (combinational, from `full` and pointer `ptr`):
  - `sel` is the first full unit searching `ptr`, `ptr+1`, …, wrapping modulo `NUM_UNITS`.
  - `sel` is all-zero if no buffer is full.
- Pointer update:
  - If `sel` is nonzero with winner k, `ptr <= (k+1) mod NUM_UNITS`.
  - Otherwise `ptr` holds.
- Output stage (registered):
  - `write_back_output <= |sel`.
  - `write_back_register_output <= reg[k]`, `result_output <= data[k]`, `grant_output <= sel`.
  - When `sel` is zero, register/result outputs hold their last value.
- Scheduling is per unit only. Two units targeting the same register are written in grant order. Preventing duplicate in-flight writers is the issue logic's job via reservation bits.
- Reset (`rst==0` at an edge), including mid-operation:
  - All `full` cleared and pending results dropped.
  - `ptr=0`.
  - `write_back_output=0`, `write_back_register_output=0`, `result_output=0`, `grant_output=0`.
  - `req_ready_output` is all ones from the first cycle after reset.

## Timing

- Accept in cycle N → buffer full in N+1 → earliest `write_back_output` in N+2 (2-cycle latency).
- Throughput: one write-back per cycle aggregate; one per cycle per unit when it is the only requester.
- With all units continuously requesting, each unit is granted exactly once every `NUM_UNITS` cycles.
- Worst-case wait once full: `NUM_UNITS`−1 cycles.
- `req_ready_output` is combinational from state only and never depends on `req_valid_input` (no combinational loop).
- Outputs are all registered except `req_ready_output` and `busy_output`.

## Structure

- Shared params package: add `NUM_WB_UNITS` (default 4). Reuse `OPERAND_WIDTH`, `REGISTER_DESCRIPTOR_WIDTH`, `REGISTER_SIZE`.
- Sub-module `round_robin_arbiter`: combinational, `NUM_UNITS` request vector plus pointer in, one-hot grant out. It has no state and is reusable by other schedulers.
- `writeback_arbiter` owns the buffers, `ptr` and the output stage.

## Test plan

Use `NUM_UNITS=4`, `OPERAND_WIDTH=32`.

1. Reset with garbage on inputs, `rst=0` for 2 cycles → all outputs 0, `req_ready_output=4'b1111`, `busy_output=0`.
2. Single request from unit 2 (r5, 0xDEADBEEF) in cycle N → cycle N+2 shows `write_back_output=1`, register 5, 0xDEADBEEF, `grant_output=4'b0100`; cycle N+3 shows `write_back_output=0`.
3. All 4 units valid in the same cycle (r1..r4, data 0x11..0x44) → write-backs in 4 consecutive cycles in order unit0, 1, 2, 3; `ptr` ends at 0.
4. Units 0 and 1 held valid continuously after `ptr=1` → grants alternate 1, 0, 1, 0…; both `req_ready_output` stay 1 while each buffer drains, and no result is lost or duplicated (check against a scoreboard).
5. Unit 3 valid while its buffer is full and not selected → `req_ready_output[3]=0`, input ignored; the original value is written when granted.
6. Assert `rst=0` while 3 buffers are full → no `write_back_output` after the reset edge, buffers empty; a new request then writes back with 2-cycle latency.
